// File: rtl/key_cmd_ctrl_if.sv
// rtl/key_cmd_ctrl_if.sv - keypad command bus between scanner/host and key_cmd_ctrl
//
// Signals:
//   sample_en  keypad scan strobe, one cycle per scan
//   key_code   5-bit keypad code (0..15 key index, 16..31 no key)
//   motor_cmd  registered drive state
//   speed      registered speed setpoint
//   estop      high while motor_cmd is ESTOP
//   cmd_valid  one-cycle pulse when a mapped key has been applied
// Modports: master drives the keypad side, slave is the controller.
interface key_cmd_ctrl_if;
  logic       sample_en;
  logic [4:0] key_code;
  logic [2:0] motor_cmd;
  logic [2:0] speed;
  logic       estop;
  logic       cmd_valid;

  modport master (
    output sample_en,
    output key_code,
    input  motor_cmd,
    input  speed,
    input  estop,
    input  cmd_valid
  );

  modport slave (
    input  sample_en,
    input  key_code,
    output motor_cmd,
    output speed,
    output estop,
    output cmd_valid
  );
endinterface

// File: rtl/key_cmd_ctrl.sv
// rtl/key_cmd_ctrl.sv - debounced keypad to motor command controller
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   kc_if  key_cmd_ctrl_if.slave: sample_en/key_code in,
//          motor_cmd/speed/estop/cmd_valid out (all registered)
// A key must be seen on STABLE_CNT consecutive strobes, after a release of
// the same length, before it is accepted. The accepted key is applied to the
// drive state machine on the following clock edge.
module key_cmd_ctrl #(
  parameter int STABLE_CNT = 3,
  parameter int MAX_SPEED  = 7
) (
  input  logic          clk,
  input  logic          rst,
  key_cmd_ctrl_if.slave kc_if
);

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);
  localparam logic [2:0] MAXSPD = 3'(MAX_SPEED);
  localparam logic [4:0] NO_KEY = 5'd31;

  typedef enum logic [2:0] {
    ST_STOP  = 3'b000,
    ST_FWD   = 3'b001,
    ST_REV   = 3'b010,
    ST_LEFT  = 3'b011,
    ST_RIGHT = 3'b100,
    ST_ESTOP = 3'b111
  } state_e;

  state_e     state_q;
  logic [2:0] speed_q;
  logic       estop_q;
  logic       cmd_valid_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [4:0] code_q;
  logic       armed_q;
  logic       pend_q;     // a key was accepted on the previous edge
  logic [3:0] acc_key_q;  // the key accepted on that edge

  logic [4:0] code_n;
  logic       is_key;
  logic       reach;
  logic       accept;
  logic       arm;

  // All no-key codes collapse to one value so 16..31 count as the same code.
  assign code_n = kc_if.key_code[4] ? NO_KEY : kc_if.key_code;
  assign is_key = ~code_n[4];
  assign cnt_d  = (code_n != code_q) ? 4'd1 :
                  (cnt_q >= STABLE)  ? STABLE : cnt_q + 4'd1;
  assign reach  = (cnt_d == STABLE);
  // Armed is cleared on acceptance, so a saturated held key cannot re-fire.
  assign accept = reach && is_key && armed_q;
  assign arm    = reach && !is_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_STOP;
      speed_q     <= 3'd0;
      estop_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cnt_q       <= 4'd0;
      code_q      <= NO_KEY;
      armed_q     <= 1'b0;
      pend_q      <= 1'b0;
      acc_key_q   <= 4'd0;
    end else begin
      cmd_valid_q <= 1'b0;
      pend_q      <= 1'b0;

      if (pend_q) begin
        if (acc_key_q == 4'd15) begin
          state_q     <= ST_ESTOP;
          estop_q     <= 1'b1;
          speed_q     <= 3'd0;
          cmd_valid_q <= 1'b1;
        end else if (state_q == ST_ESTOP) begin
          // Only stop releases the emergency stop; everything else is dropped.
          if (acc_key_q == 4'd5) begin
            state_q     <= ST_STOP;
            estop_q     <= 1'b0;
            cmd_valid_q <= 1'b1;
          end
        end else begin
          case (acc_key_q)
            4'd5: begin
              state_q     <= ST_STOP;
              cmd_valid_q <= 1'b1;
            end
            4'd2: begin
              // Reversing direction passes through STOP first.
              state_q     <= (state_q == ST_REV) ? ST_STOP : ST_FWD;
              cmd_valid_q <= 1'b1;
            end
            4'd8: begin
              state_q     <= (state_q == ST_FWD) ? ST_STOP : ST_REV;
              cmd_valid_q <= 1'b1;
            end
            4'd4: begin
              state_q     <= ST_LEFT;
              cmd_valid_q <= 1'b1;
            end
            4'd6: begin
              state_q     <= ST_RIGHT;
              cmd_valid_q <= 1'b1;
            end
            4'd10: begin
              if (speed_q < MAXSPD) speed_q <= speed_q + 3'd1;
              cmd_valid_q <= 1'b1;
            end
            4'd11: begin
              if (speed_q != 3'd0) speed_q <= speed_q - 3'd1;
              cmd_valid_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end

      if (kc_if.sample_en) begin
        code_q <= code_n;
        cnt_q  <= cnt_d;
        if (accept) begin
          pend_q    <= 1'b1;
          acc_key_q <= code_n[3:0];
          armed_q   <= 1'b0;
        end else if (arm) begin
          armed_q <= 1'b1;
        end
      end
    end
  end

  assign kc_if.motor_cmd = state_q;
  assign kc_if.speed     = speed_q;
  assign kc_if.estop     = estop_q;
  assign kc_if.cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// tb/tb_key_cmd_ctrl.sv - self-checking bench for key_cmd_ctrl
module tb_key_cmd_ctrl;

  localparam int S    = 3;
  localparam int MAXS = 7;

  localparam int M_STOP  = 0;
  localparam int M_FWD   = 1;
  localparam int M_REV   = 2;
  localparam int M_LEFT  = 3;
  localparam int M_RIGHT = 4;
  localparam int M_ESTOP = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  key_cmd_ctrl_if kif ();

  key_cmd_ctrl #(.STABLE_CNT(S), .MAX_SPEED(MAXS)) dut (
    .clk   (clk),
    .rst   (rst),
    .kc_if (kif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_pulse = 0;
  bit saw_fwd = 0;

  // Reference model: last strobe code, run length, release-armed flag,
  // and a key waiting to be applied on the next edge.
  int m_code, m_run, m_pkey, m_state, m_speed;
  bit m_armed, m_pend, m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_apply(input int k);
    if (k == 15) begin
      m_state = M_ESTOP; m_speed = 0; m_valid = 1;
    end else if (m_state == M_ESTOP) begin
      if (k == 5) begin m_state = M_STOP; m_valid = 1; end
    end else begin
      case (k)
        5:  begin m_state = M_STOP; m_valid = 1; end
        2:  begin m_state = (m_state == M_REV) ? M_STOP : M_FWD; m_valid = 1; end
        8:  begin m_state = (m_state == M_FWD) ? M_STOP : M_REV; m_valid = 1; end
        4:  begin m_state = M_LEFT;  m_valid = 1; end
        6:  begin m_state = M_RIGHT; m_valid = 1; end
        10: begin m_speed = (m_speed + 1 > MAXS) ? MAXS : m_speed + 1; m_valid = 1; end
        11: begin m_speed = (m_speed - 1 < 0) ? 0 : m_speed - 1; m_valid = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic model_edge(input bit r, input bit se, input int kc);
    int c;
    m_valid = 0;
    if (r) begin
      m_state = M_STOP; m_speed = 0; m_code = 31; m_run = 0;
      m_armed = 0; m_pend = 0;
    end else begin
      if (m_pend) begin
        model_apply(m_pkey);
        m_pend = 0;
      end
      if (se) begin
        c = (kc >= 16) ? 31 : kc;
        if (c == m_code) m_run = (m_run + 1 > S) ? S : m_run + 1;
        else begin m_run = 1; m_code = c; end
        if (m_run == S) begin
          if (c == 31) m_armed = 1;
          else if (m_armed) begin
            m_pend = 1; m_pkey = c; m_armed = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit se, input logic [4:0] kc);
    rst = r;
    kif.sample_en = se;
    kif.key_code = kc;
    @(posedge clk);
    model_edge(r, se, int'(kc));
    #1;
    check("motor_cmd", 32'(kif.motor_cmd), 32'(m_state));
    check("speed", 32'(kif.speed), 32'(m_speed));
    check("estop", 32'(kif.estop), 32'(m_state == M_ESTOP));
    check("cmd_valid", 32'(kif.cmd_valid), 32'(m_valid));
    if (kif.cmd_valid) n_pulse++;
    if (kif.motor_cmd == 3'b001) saw_fwd = 1;
  endtask

  task automatic strobe(input logic [4:0] kc);
    cyc(0, 1, kc);
    cyc(0, 0, kc);
  endtask

  task automatic press(input logic [4:0] kc);
    for (int i = 0; i < S; i++) strobe(5'd31);
    for (int i = 0; i < S; i++) strobe(kc);
  endtask

  logic [2:0] mc_before, sp_before;
  int k, hold, gap;
  logic [4:0] tbl [8] = '{5'd2, 5'd8, 5'd4, 5'd6, 5'd5, 5'd10, 5'd11, 5'd15};

  initial begin
    kif.sample_en = 0;
    kif.key_code = 5'd31;
    cyc(1, 0, 5'd31);
    cyc(1, 0, 5'd31);
    check("rst_motor", 32'(kif.motor_cmd), 32'd0);
    check("rst_speed", 32'(kif.speed), 32'd0);
    check("rst_valid", 32'(kif.cmd_valid), 32'd0);

    // release then hold forward
    for (int i = 0; i < 3; i++) strobe(5'd31);
    n_pulse = 0;
    for (int i = 0; i < 13; i++) strobe(5'd2);
    check("fwd_motor", 32'(kif.motor_cmd), 32'd1);
    check("fwd_pulses", 32'(n_pulse), 32'd1);

    // speed up to saturation
    n_pulse = 0;
    for (int i = 0; i < 8; i++) press(5'd10);
    check("spd_sat", 32'(kif.speed), 32'd7);
    check("spd_pulses", 32'(n_pulse), 32'd8);

    // reversal, e-stop, ignored key, exit
    press(5'd11); press(5'd11);
    check("spd5", 32'(kif.speed), 32'd5);
    press(5'd8);
    check("rev_stop", 32'(kif.motor_cmd), 32'd0);
    check("rev_speed", 32'(kif.speed), 32'd5);
    press(5'd15);
    check("es_motor", 32'(kif.motor_cmd), 32'd7);
    check("es_speed", 32'(kif.speed), 32'd0);
    check("es_flag", 32'(kif.estop), 32'd1);
    n_pulse = 0;
    press(5'd2);
    check("es_ign", 32'(kif.motor_cmd), 32'd7);
    check("es_ign_pulse", 32'(n_pulse), 32'd0);
    press(5'd5);
    check("es_exit", 32'(kif.motor_cmd), 32'd0);
    check("es_clr", 32'(kif.estop), 32'd0);

    // key held through reset never fires
    n_pulse = 0;
    cyc(1, 1, 5'd2);
    for (int i = 0; i < 6; i++) strobe(5'd2);
    check("held_rst_motor", 32'(kif.motor_cmd), 32'd0);
    check("held_rst_pulse", 32'(n_pulse), 32'd0);

    // mid-count key change
    for (int i = 0; i < 3; i++) strobe(5'd31);
    saw_fwd = 0;
    strobe(5'd2); strobe(5'd2);
    for (int i = 0; i < 3; i++) strobe(5'd4);
    check("chg_left", 32'(kif.motor_cmd), 32'd3);
    check("chg_nofwd", 32'(saw_fwd), 32'd0);

    // strobes held off
    mc_before = kif.motor_cmd;
    sp_before = kif.speed;
    n_pulse = 0;
    press(5'd31);
    for (int i = 0; i < 100; i++) cyc(0, 0, 5'd2);
    check("idle_motor", 32'(kif.motor_cmd), 32'(mc_before));
    check("idle_speed", 32'(kif.speed), 32'(sp_before));
    check("idle_pulse", 32'(n_pulse), 32'd0);

    // randomized traffic against the model
    for (int it = 0; it < 500; it++) begin
      k = $urandom_range(0, 3);
      if (k == 0) kif.key_code = 5'($urandom_range(0, 31));
      else if (k == 1) kif.key_code = 5'd31;
      else kif.key_code = tbl[$urandom_range(0, 7)];
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        if ($urandom_range(0, 99) == 0) cyc(1, $urandom_range(0, 1) == 1, kif.key_code);
        else cyc(0, 1, kif.key_code);
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) cyc(0, 0, 5'($urandom_range(0, 31)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
